// File: rtl/uart_resp_pkg.sv
// Shared constants and FSM encoding for the UART register-access responder.
package uart_resp_pkg;

  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam int         CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GET_DATA  = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_resp_regfile.sv
// NREGS x 8 register file: one synchronous write port, combinational read mux,
// and the whole array exposed as a flat bus for configuration consumers.
module uart_resp_regfile #(
  parameter int ADDRWIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ADDRWIDTH-1:0]          waddr,
  input  logic [7:0]                    wdata,
  input  logic [ADDRWIDTH-1:0]          raddr,
  output logic [7:0]                    rdata,
  output logic [8*(2**ADDRWIDTH)-1:0]   regs
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else if (we) begin
      regs[{waddr, 3'b000} +: 8] <= wdata;
    end
  end

  assign rdata = regs[{raddr, 3'b000} +: 8];

endmodule

// File: rtl/uart_reg_responder.sv
// Register-access responder: decodes read/write commands arriving on the UART
// receive side and answers each one with a single reply byte.
//
// state        | meaning
// ST_IDLE      | waiting for a command byte
// ST_GET_DATA  | write command accepted, waiting for its data byte (timed)
// ST_SEND      | reply loaded, waiting for the transmitter to go idle
// ST_WAIT_DONE | reply requested, waiting for the frame to finish
module uart_reg_responder
  import uart_resp_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int TIMEOUT   = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          parity_error,
  input  logic                          parity_error_valid,
  input  logic                          framing_error,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_valid,
  output logic [8*(2**ADDRWIDTH)-1:0]   regs,
  output logic                          wr_strobe,
  output logic [ADDRWIDTH-1:0]          wr_addr,
  output logic [7:0]                    drop_cnt
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [CW-1:0]        tmo_cnt;
  logic [7:0]           rd_data;
  logic [7:0]           tx_data_nxt;
  logic                 rx_bad, rx_good, cmd_illegal, tmo_hit;
  logic                 tx_valid_nxt, we, addr_load, drop;

  assign rx_bad      = rx_done & (framing_error | (parity_error_valid & parity_error));
  assign rx_good     = rx_done & ~rx_bad;
  assign cmd_illegal = (rx_data[6:0] >> ADDRWIDTH) != 7'd0;
  assign tmo_hit     = (tmo_cnt == CW'(TIMEOUT - 1));

  uart_resp_regfile #(.ADDRWIDTH(ADDRWIDTH)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (cmd_addr),
    .wdata (rx_data),
    .raddr (rx_data[ADDRWIDTH-1:0]),
    .rdata (rd_data),
    .regs  (regs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = 1'b0;
    we           = 1'b0;
    addr_load    = 1'b0;
    drop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_bad || (rx_good && cmd_illegal)) begin
          tx_data_nxt = NAK;
          state_nxt   = ST_SEND;
        end else if (rx_good && rx_data[CMD_WR_BIT]) begin
          addr_load = 1'b1;
          state_nxt = ST_GET_DATA;
        end else if (rx_good) begin
          tx_data_nxt = rd_data;
          state_nxt   = ST_SEND;
        end
      end
      ST_GET_DATA: begin
        // a byte landing on the terminal count still counts as the data byte
        if (rx_bad || (!rx_done && tmo_hit)) begin
          tx_data_nxt = NAK;
          state_nxt   = ST_SEND;
        end else if (rx_good) begin
          we          = 1'b1;
          tx_data_nxt = ACK;
          state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        drop = rx_done;
        if (!tx_busy) begin
          tx_valid_nxt = 1'b1;
          state_nxt    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        drop = rx_done;
        if (tx_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      wr_strobe     <= 1'b0;
      wr_addr       <= '0;
      cmd_addr      <= '0;
      tmo_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      tx_data       <= tx_data_nxt;
      tx_data_valid <= tx_valid_nxt;
      wr_strobe     <= we;
      if (we) wr_addr <= cmd_addr;
      if (addr_load) begin
        cmd_addr <= rx_data[ADDRWIDTH-1:0];
        tmo_cnt  <= '0;
      end else if (state == ST_GET_DATA) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
